// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle datapath controller.
// Covers state names, opcodes, ALU/mux selects and the state-to-control decode.
package mc_ctrl_fsm_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI = 6'h0A;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'd3;

  localparam logic [SEL_W-1:0] SRCB_B       = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  // Control outputs that depend on state only (input-qualified pulses live in the top).
  typedef struct packed {
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic               pc_write;
    logic               pc_write_cond;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
  } ctrl_t;

  // Per-state control word; slt_sel picks the EXEC_I ALU operation.
  function automatic ctrl_t state_ctrl(input state_t s, input logic slt_sel);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = slt_sel ? ALUOP_SLT : ALUOP_ADD;
      end
      S_I_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Control word is registered from the next state so it lines up with the state register.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                IorD_o,
  output logic                IRWrite_o,
  output logic                RegWrite_o,
  output logic                RegDst_o,
  output logic                MemtoReg_o,
  output logic                ALUSrcA_o,
  output logic                PCWrite_o,
  output logic                PCWriteCond_o,
  output logic [SEL_W-1:0]    ALUSrcB_o,
  output logic [SEL_W-1:0]    PCSource_o,
  output logic [ALUOP_W-1:0]  ALUOp_o,
  output logic                instr_done_o,
  output logic                illegal_o
);

  state_t state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   slt_sel_q, slt_sel_d;
  logic   op_legal;
  ctrl_t  ctrl_q, ctrl_d;
  logic   fetch_done;
  logic   store_done;

  // Next-state, decode capture and next control word.
  always_comb begin
    state_d   = state_q;
    is_sw_d   = is_sw_q;
    slt_sel_d = slt_sel_q;
    op_legal  = 1'b1;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d   = (opcode_i == OP_SW);
        slt_sel_d = (opcode_i == OP_SLTI);
        case (opcode_i)
          OP_R:             state_d = S_EXEC_R;
          OP_LW, OP_SW:     state_d = S_MEMADDR;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            state_d  = S_IDLE;
            op_legal = 1'b0;
          end
        endcase
      end
      S_MEMADDR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:  state_d = S_R_WB;
      S_R_WB:    state_d = S_FETCH;
      S_EXEC_I:  state_d = S_I_WB;
      S_I_WB:    state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
    ctrl_d = state_ctrl(state_d, slt_sel_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      is_sw_q   <= 1'b0;
      slt_sel_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_sw_q   <= is_sw_d;
      slt_sel_q <= slt_sel_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Completion strobes only fire in the cycle the memory handshake closes.
  assign fetch_done = (state_q == S_FETCH) & mem_ready_i;
  assign store_done = (state_q == S_MEMWR) & mem_ready_i;

  assign mem_req_o     = ctrl_q.mem_req;
  assign mem_we_o      = ctrl_q.mem_we;
  assign IorD_o        = ctrl_q.iord;
  assign IRWrite_o     = fetch_done;
  assign RegWrite_o    = ctrl_q.reg_write;
  assign RegDst_o      = ctrl_q.reg_dst;
  assign MemtoReg_o    = ctrl_q.mem_to_reg;
  assign ALUSrcA_o     = ctrl_q.alu_src_a;
  assign PCWrite_o     = ctrl_q.pc_write | fetch_done;
  assign PCWriteCond_o = ctrl_q.pc_write_cond;
  assign ALUSrcB_o     = ctrl_q.alu_src_b;
  assign PCSource_o    = ctrl_q.pc_source;
  assign ALUOp_o       = ctrl_q.alu_op;
  assign instr_done_o  = ctrl_q.instr_done | store_done;
  assign illegal_o     = (state_q == S_DECODE) & ~op_legal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: expected per-cycle outputs are expanded
// from each instruction's phase sequence, with don't-care inputs randomized.
module tb_mc_ctrl_fsm;

  localparam int OBS_W  = 19;
  localparam int B_ILL  = 0;
  localparam int B_DONE = 1;
  localparam int B_ALU  = 2;
  localparam int B_PCS  = 5;
  localparam int B_SRCB = 7;
  localparam int B_PCWC = 9;
  localparam int B_PCW  = 10;
  localparam int B_SA   = 11;
  localparam int B_M2R  = 12;
  localparam int B_RDST = 13;
  localparam int B_RW   = 14;
  localparam int B_IRW  = 15;
  localparam int B_IORD = 16;
  localparam int B_WE   = 17;
  localparam int B_REQ  = 18;

  typedef struct {
    logic             rst;
    logic [5:0]       op;
    logic             rdy;
    logic [OBS_W-1:0] exp;
    int               id;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, IorD_o, IRWrite_o, RegWrite_o, RegDst_o;
  logic       MemtoReg_o, ALUSrcA_o, PCWrite_o, PCWriteCond_o;
  logic [1:0] ALUSrcB_o, PCSource_o;
  logic [2:0] ALUOp_o;
  logic       instr_done_o, illegal_o;
  logic [OBS_W-1:0] obs;

  step_t            plan[$];
  logic [OBS_W-1:0] seen[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .RegDst_o(RegDst_o),
    .MemtoReg_o(MemtoReg_o), .ALUSrcA_o(ALUSrcA_o), .PCWrite_o(PCWrite_o),
    .PCWriteCond_o(PCWriteCond_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
    .ALUOp_o(ALUOp_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  assign obs = {mem_req_o, mem_we_o, IorD_o, IRWrite_o, RegWrite_o, RegDst_o,
                MemtoReg_o, ALUSrcA_o, PCWrite_o, PCWriteCond_o, ALUSrcB_o,
                PCSource_o, ALUOp_o, instr_done_o, illegal_o};

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h02};
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [OBS_W-1:0] exp, input int id);
    step_t s;
    s.rst = rst; s.op = op; s.rdy = rdy; s.exp = exp; s.id = id;
    plan.push_back(s);
  endtask

  // Fetch (with fw wait cycles) followed by the decode cycle.
  task automatic add_front(input logic [5:0] op, input int fw, input int id);
    logic [OBS_W-1:0] e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e[B_REQ] = 1'b1; e[B_SRCB +: 2] = 2'd1;
      push(1'b0, rop(), 1'b0, e, id);
    end
    e = '0; e[B_REQ] = 1'b1; e[B_SRCB +: 2] = 2'd1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1;
    push(1'b0, rop(), 1'b1, e, id);
    e = '0; e[B_SRCB +: 2] = 2'd3; e[B_ILL] = !is_legal(op);
    push(1'b0, op, rbit(), e, id);
  endtask

  // Whole instruction: fw fetch waits, mw data-memory waits.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input int id);
    logic [OBS_W-1:0] e;
    add_front(op, fw, id);
    if (!is_legal(op)) begin
      push(1'b0, rop(), rbit(), '0, id);
      return;
    end
    case (op)
      6'h00: begin
        e = '0; e[B_SA] = 1'b1; e[B_ALU +: 3] = 3'd2;
        push(1'b0, rop(), rbit(), e, id);
        e = '0; e[B_RW] = 1'b1; e[B_RDST] = 1'b1; e[B_DONE] = 1'b1;
        push(1'b0, rop(), rbit(), e, id);
      end
      6'h23, 6'h2B: begin
        e = '0; e[B_SA] = 1'b1; e[B_SRCB +: 2] = 2'd2;
        push(1'b0, rop(), rbit(), e, id);
        e = '0; e[B_REQ] = 1'b1; e[B_IORD] = 1'b1; e[B_WE] = (op == 6'h2B);
        for (int i = 0; i < mw; i++) push(1'b0, rop(), 1'b0, e, id);
        if (op == 6'h2B) begin
          e[B_DONE] = 1'b1;
          push(1'b0, rop(), 1'b1, e, id);
        end else begin
          push(1'b0, rop(), 1'b1, e, id);
          e = '0; e[B_RW] = 1'b1; e[B_M2R] = 1'b1; e[B_DONE] = 1'b1;
          push(1'b0, rop(), rbit(), e, id);
        end
      end
      6'h08, 6'h0A: begin
        e = '0; e[B_SA] = 1'b1; e[B_SRCB +: 2] = 2'd2;
        e[B_ALU +: 3] = (op == 6'h0A) ? 3'd3 : 3'd0;
        push(1'b0, rop(), rbit(), e, id);
        e = '0; e[B_RW] = 1'b1; e[B_DONE] = 1'b1;
        push(1'b0, rop(), rbit(), e, id);
      end
      6'h04: begin
        e = '0; e[B_SA] = 1'b1; e[B_ALU +: 3] = 3'd1; e[B_PCWC] = 1'b1;
        e[B_PCS +: 2] = 2'd1; e[B_DONE] = 1'b1;
        push(1'b0, rop(), rbit(), e, id);
      end
      default: begin
        e = '0; e[B_PCW] = 1'b1; e[B_PCS +: 2] = 2'd2; e[B_DONE] = 1'b1;
        push(1'b0, rop(), rbit(), e, id);
      end
    endcase
  endtask

  // Drive the plan one cycle per step, sampling just after the falling edge.
  task automatic run_plan();
    seen.delete();
    foreach (plan[i]) begin
      @(negedge clk);
      rst_i       = plan[i].rst;
      opcode_i    = plan[i].op;
      mem_ready_i = plan[i].rdy;
      #1;
      seen.push_back(obs);
    end
  endtask

  task automatic test_reset();
    plan.delete();
    for (int i = 0; i < 3; i++) push(1'b1, rop(), rbit(), '0, 0);
    push(1'b0, rop(), rbit(), '0, 0);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL reset step %0d: outputs=%b required=%b", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_rtype();
    plan.delete();
    add_instr(6'h00, 0, 0, 1);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL rtype step %0d: outputs=%b required=%b", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_lw_wait();
    plan.delete();
    add_instr(6'h23, 0, 2, 2);
    run_plan();
    checks++;
    if (plan.size() != 7) begin
      failures++;
      $display("FAIL lw_length: cycles=%0d required=7", plan.size());
    end
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL lw_wait step %0d: outputs=%b required=%b", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_imm();
    plan.delete();
    add_instr(6'h0A, 0, 0, 3);
    add_instr(6'h08, 1, 0, 4);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL imm step %0d instr %0d: outputs=%b required=%b", i, plan[i].id, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    plan.delete();
    add_instr(6'h04, 0, 0, 5);
    add_instr(6'h02, 0, 0, 6);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL branch_jump step %0d instr %0d: outputs=%b required=%b", i, plan[i].id, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    plan.delete();
    add_instr(6'h3F, 0, 0, 7);
    add_instr(6'h2B, 2, 3, 8);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL illegal_sw step %0d instr %0d: outputs=%b required=%b", i, plan[i].id, seen[i], plan[i].exp);
      end
    end
  endtask

  // Reset held three cycles while a load waits in MEMRD.
  task automatic test_reset_mid_access();
    logic [OBS_W-1:0] e;
    plan.delete();
    add_front(6'h23, 0, 9);
    e = '0; e[B_SA] = 1'b1; e[B_SRCB +: 2] = 2'd2;
    push(1'b0, rop(), rbit(), e, 9);
    e = '0; e[B_REQ] = 1'b1; e[B_IORD] = 1'b1;
    push(1'b0, rop(), 1'b0, e, 9);
    push(1'b1, rop(), 1'b0, e, 9);
    push(1'b1, rop(), 1'b0, '0, 9);
    push(1'b1, rop(), 1'b0, '0, 9);
    push(1'b0, rop(), 1'b0, '0, 9);
    e = '0; e[B_REQ] = 1'b1; e[B_SRCB +: 2] = 2'd1;
    push(1'b0, rop(), 1'b0, e, 9);
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL reset_mid_access step %0d: outputs=%b required=%b", i, seen[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    int sel;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h02};
    plan.delete();
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 8));
      if (sel < 7) op = legal_ops[sel];
      else begin
        op = rop();
        if (is_legal(op)) op = 6'h3F;
      end
      add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 100 + n);
    end
    run_plan();
    foreach (plan[i]) begin
      checks++;
      if (seen[i] !== plan[i].exp) begin
        failures++;
        $display("FAIL random step %0d instr %0d op %h: outputs=%b required=%b",
                 i, plan[i].id, plan[i].op, seen[i], plan[i].exp);
      end
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    opcode_i    = 6'h00;
    mem_ready_i = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_imm();
    test_branch_jump();
    test_illegal();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
